// File: rtl/data_ram_sync.sv
// Synchronous banked data RAM with byte-enable writes, a valid-tagged registered read
// and a hardware zero-fill sweep that runs after reset or on clear_req.
module data_ram_sync #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 10,
    parameter int BANK_W = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req,
    input  logic                  we,
    input  logic [BANK_W-1:0]     bank,
    input  logic [ADDR_W-1:0]     addr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [DATA_W/8-1:0]   be,
    input  logic                  clear_req,
    output logic                  ready,
    output logic                  rd_valid,
    output logic [DATA_W-1:0]     rdata
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = BANK_W + ADDR_W;
    localparam int DEPTH = 1 << IDX_W;

    typedef enum logic {
        ST_INIT,
        ST_IDLE
    } state_t;

    state_t              state_q;
    logic [IDX_W-1:0]    cnt_q;
    logic                ready_q;
    logic                rd_valid_q;
    logic [DATA_W-1:0]   rdata_q;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [IDX_W-1:0]    acc_idx;
    logic                accept;
    logic                wr_en;
    logic                rd_en;
    logic                sweep_en;

    // The bank select forms the top bits of one flat word index, so every {bank,addr} is legal.
    assign acc_idx  = {bank, addr};
    assign accept   = req && ready_q;
    assign wr_en    = accept && we;
    assign rd_en    = accept && !we;
    assign sweep_en = (state_q == ST_INIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_INIT;
            cnt_q      <= '0;
            ready_q    <= 1'b0;
            rd_valid_q <= 1'b0;
            rdata_q    <= '0;
        end else begin
            rd_valid_q <= rd_en;
            if (rd_en) begin
                rdata_q <= mem[acc_idx];
            end
            case (state_q)
                ST_INIT: begin
                    // cnt wraps back to zero on the last word, leaving it ready for the next sweep.
                    cnt_q <= cnt_q + IDX_W'(1);
                    if (cnt_q == '1) begin
                        state_q <= ST_IDLE;
                        ready_q <= 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (clear_req) begin
                        cnt_q   <= '0;
                        state_q <= ST_INIT;
                        ready_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_INIT;
                    ready_q <= 1'b0;
                end
            endcase
        end
    end

    // NOTE: the array has no reset so it maps onto RAM macros; the sweep provides the clear.
    always_ff @(posedge clk) begin
        if (sweep_en) begin
            mem[cnt_q] <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < BYTES; i++) begin
                if (be[i]) begin
                    mem[acc_idx][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    assign ready    = ready_q;
    assign rd_valid = rd_valid_q;
    assign rdata    = rdata_q;

endmodule

// File: tb/tb_data_ram_sync.sv
// Scoreboard bench for data_ram_sync: a flat word-array model predicts reads, and a
// negedge monitor pops predictions whenever rd_valid is presented.
module tb_data_ram_sync;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 10;
    localparam int BANK_W = 1;
    localparam int DEPTH  = (1 << BANK_W) * (1 << ADDR_W);

    logic                clk = 1'b0;
    logic                rst_n = 1'b0;
    logic                req = 1'b0;
    logic                we = 1'b0;
    logic [BANK_W-1:0]   bank = '0;
    logic [ADDR_W-1:0]   addr = '0;
    logic [DATA_W-1:0]   wdata = '0;
    logic [DATA_W/8-1:0] be = '0;
    logic                clear_req = 1'b0;
    logic                ready;
    logic                rd_valid;
    logic [DATA_W-1:0]   rdata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [DATA_W-1:0] ref_mem [DEPTH];
    logic [DATA_W-1:0] exp_q [$];

    data_ram_sync #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .BANK_W(BANK_W)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .bank(bank), .addr(addr),
        .wdata(wdata), .be(be), .clear_req(clear_req), .ready(ready),
        .rd_valid(rd_valid), .rdata(rdata)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a plain word array indexed by bank*words_per_bank + addr.
    function automatic int flat(input int b, input int a);
        return b * (1 << ADDR_W) + a;
    endfunction

    task automatic model_clear();
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    // Issue one access in IDLE; the model commits writes and predicts reads at issue time.
    task automatic op(input logic is_wr, input int b, input int a,
                      input logic [DATA_W-1:0] d, input logic [DATA_W/8-1:0] e);
        check("ready_at_issue", ready, 1);
        req = 1'b1; we = is_wr; bank = BANK_W'(b); addr = ADDR_W'(a); wdata = d; be = e;
        if (is_wr) begin
            for (int i = 0; i < DATA_W / 8; i++)
                if (e[i]) ref_mem[flat(b, a)][8*i +: 8] = d[8*i +: 8];
        end else begin
            exp_q.push_back(ref_mem[flat(b, a)]);
        end
        @(posedge clk); #1;
    endtask

    task automatic idle();
        req = 1'b0; we = 1'b0; be = '0;
    endtask

    task automatic wait_sweep(input string name);
        int n = 0;
        while (n < 5000) begin
            @(posedge clk); #1;
            n++;
            if (ready) break;
        end
        check(name, n, DEPTH);
    endtask

    task automatic settle_and_drain(input string name);
        idle();
        repeat (3) @(posedge clk);
        #1;
        check(name, exp_q.size(), 0);
    endtask

    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL spurious_rd_valid: got rd_valid=1 rdata=0x%0h, expected no read result at %0t",
                         rdata, $time);
            end else begin
                check("read_data", rdata, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within the time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        model_clear();
        #2;
        check("reset_ready", ready, 0);
        check("reset_rd_valid", rd_valid, 0);
        check("reset_rdata", rdata, 0);

        // Power-up sweep
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_sweep("sweep_after_reset");

        op(0, 0, 25, '0, '0);
        // Full write then same-word read, and bank isolation
        op(1, 0, 639, 16'hFE63, 2'b11);
        op(0, 0, 639, '0, '0);
        op(0, 1, 639, '0, '0);
        // Partial byte write, then be=0 no-op write
        op(1, 0, 639, 16'h00AA, 2'b01);
        op(0, 0, 639, '0, '0);
        op(1, 0, 639, 16'h5555, 2'b00);
        op(0, 0, 639, '0, '0);
        // Top address of the top bank, then bottom address
        op(1, 1, 1023, 16'h1234, 2'b11);
        op(0, 1, 1023, '0, '0);
        op(0, 0, 0, '0, '0);
        settle_and_drain("drain_directed");

        // Randomised traffic biased towards edge addresses, with occasional idle gaps
        repeat (400) begin
            int sel;
            int a;
            sel = $urandom_range(0, 3);
            a = (sel == 0) ? 0 : (sel == 1) ? 1023 : (sel == 2) ? 639 : $urandom_range(0, 1023);
            op(1'($urandom_range(0, 1)), $urandom_range(0, 1), a,
               DATA_W'($urandom), 2'($urandom_range(0, 3)));
            if ($urandom_range(0, 5) == 0) begin
                idle();
                @(posedge clk); #1;
            end
        end
        settle_and_drain("drain_random");

        // clear_req with a simultaneous read: the read completes, then the sweep runs
        op(1, 0, 5, 16'h7777, 2'b11);
        clear_req = 1'b1;
        op(0, 0, 5, '0, '0);
        clear_req = 1'b0;
        idle();
        check("ready_drop_after_clear", ready, 0);
        model_clear();
        n = 0;
        while (n < 5000) begin
            @(posedge clk); #1;
            n++;
            req = 1'b0; we = 1'b0; clear_req = 1'b0; be = '0;
            if (ready) break;
            case (n)
                100:  begin req = 1'b1; we = 1'b0; bank = 1'b0; addr = 10'd639; end
                1000: clear_req = 1'b1;
                1500: begin req = 1'b1; we = 1'b1; bank = 1'b0; addr = 10'd5;
                            wdata = 16'hBEEF; be = 2'b11; end
                1800: begin req = 1'b1; we = 1'b0; bank = 1'b0; addr = 10'd5; end
                default: ;
            endcase
        end
        check("sweep_after_clear", n, DEPTH);
        op(0, 0, 639, '0, '0);
        op(0, 0, 5, '0, '0);
        op(0, 1, 1023, '0, '0);
        settle_and_drain("drain_after_clear");

        // Reset arriving just after a read is accepted
        op(1, 1, 7, 16'h5A5A, 2'b11);
        req = 1'b1; we = 1'b0; bank = 1'b1; addr = 10'd7;
        @(posedge clk); #1;
        idle();
        check("rd_valid_before_reset", rd_valid, 1);
        check("rdata_before_reset", rdata, 16'h5A5A);
        rst_n = 1'b0;
        #1;
        check("rd_valid_in_reset", rd_valid, 0);
        check("rdata_in_reset", rdata, 0);
        check("ready_in_reset", ready, 0);
        exp_q.delete();
        model_clear();
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Reset again partway through the sweep; the sweep must restart in full
        repeat (700) @(posedge clk);
        #1;
        check("ready_low_mid_sweep", ready, 0);
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        wait_sweep("sweep_after_mid_reset");
        op(0, 1, 7, '0, '0);
        op(0, 0, 639, '0, '0);
        settle_and_drain("drain_final");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
